// File: rtl/const_server_pkg.sv
// rtl/const_server_pkg.sv - shared types and helpers for the constant block server
//
// Purpose : block type, server state encoding, index-width and modular-add helpers
// Ports   : none (package)
package const_server_pkg;

  localparam int BLOCK_W = 32;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    LOADING = 2'd0,
    PRIMING = 2'd1,
    READY   = 2'd2
  } state_t;

  // Width of a block index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (base + inc) mod n, valid while base < n and inc <= n.
  function automatic int wrap_add(input int base, input int inc, input int n);
    int s;
    s = base + inc;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/const_block_mem.sv
// rtl/const_block_mem.sv - simple dual-port block store for the constant
//
// Purpose : one write port, one enabled synchronous read port, BRAM-inferable
// Ports   : clk_in                       clock
//           wr_en / wr_addr / wr_data    write port
//           rd_en / rd_addr              read request, data one cycle later
//           rd_data                      read data, held while rd_en is low
module const_block_mem
  import const_server_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = idx_w(DEPTH)
) (
  input  logic             clk_in,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or the read register so the tools map this to block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/constant_block_server.sv
// rtl/constant_block_server.sv - supplies a multi-block constant one block per consume
//
// Purpose : loads a constant once (block 0 first), then serves it block by block
//           with zero-bubble advance and rewind.
// Ports   : clk_in, rst_in (async, active-low)
//           load_valid_in / load_block_in   constant load stream
//           restart_in                      rewind to block 0
//           consumed_in                     advance to the next block
//           block_out / block_index_out     current block and its index
//           ready_out                       constant loaded, block_out valid
//           wrap_out                        pulse when index wraps to 0
//           underflow_err_out               only with CONST_SERVER_UNDERFLOW_CHK_EN:
//                                           sticky misuse flag
module constant_block_server
  import const_server_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             load_valid_in,
  input  logic [REGISTER_SIZE-1:0]         load_block_in,
  input  logic                             restart_in,
  input  logic                             consumed_in,
  output logic [REGISTER_SIZE-1:0]         block_out,
  output logic [idx_w(NUM_BLOCKS)-1:0]     block_index_out,
  output logic                             ready_out,
  output logic                             wrap_out
`ifdef CONST_SERVER_UNDERFLOW_CHK_EN
  ,
  output logic                             underflow_err_out
`endif
);

  localparam int IW = idx_w(NUM_BLOCKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLOCKS - 1);

  state_t                   state_q, state_d;
  logic [IW-1:0]            load_ptr_q, index_q;
  logic [REGISTER_SIZE-1:0] head0_q, head1_q, next_q, block_q;
  logic                     wrap_q;

  logic                     mem_wr_en, mem_rd_en;
  logic [IW-1:0]            mem_rd_addr;
  logic [REGISTER_SIZE-1:0] mem_rd_data;
  logic                     do_rewind, do_advance;

  const_block_mem #(
    .WIDTH (REGISTER_SIZE),
    .DEPTH (NUM_BLOCKS),
    .AW    (IW)
  ) u_mem (
    .clk_in  (clk_in),
    .wr_en   (mem_wr_en),
    .wr_addr (load_ptr_q),
    .wr_data (load_block_in),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= LOADING;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOADING: if (load_valid_in && load_ptr_q == LAST_IDX) state_d = PRIMING;
      PRIMING: state_d = READY;
      READY:   state_d = READY;
      default: state_d = LOADING;
    endcase
  end

  // Blocks 0 and 1 live in head registers, so the RAM only has to run two
  // blocks ahead: a rewind reads block 2 while blocks 0/1 come from registers.
  always_comb begin
    ready_out   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    do_rewind   = 1'b0;
    do_advance  = 1'b0;
    case (state_q)
      LOADING: mem_wr_en = load_valid_in;
      PRIMING: begin
        do_rewind   = 1'b1;
        mem_rd_en   = 1'b1;
        mem_rd_addr = IW'(2);
      end
      READY: begin
        ready_out = 1'b1;
        if (restart_in) begin
          do_rewind   = 1'b1;
          mem_rd_en   = 1'b1;
          mem_rd_addr = IW'(2);
        end else if (consumed_in) begin
          do_advance  = 1'b1;
          mem_rd_en   = 1'b1;
          mem_rd_addr = IW'(wrap_add(int'(index_q), 3, NUM_BLOCKS));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      load_ptr_q <= '0;
      index_q    <= '0;
      head0_q    <= '0;
      head1_q    <= '0;
      next_q     <= '0;
      block_q    <= '0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (mem_wr_en) begin
        load_ptr_q <= (load_ptr_q == LAST_IDX) ? '0 : load_ptr_q + IW'(1);
        if (load_ptr_q == IW'(0)) head0_q <= load_block_in;
        if (load_ptr_q == IW'(1)) head1_q <= load_block_in;
      end
      if (do_rewind) begin
        block_q <= head0_q;
        next_q  <= head1_q;
        index_q <= '0;
      end else if (do_advance) begin
        block_q <= next_q;
        next_q  <= mem_rd_data;
        index_q <= (index_q == LAST_IDX) ? '0 : index_q + IW'(1);
        wrap_q  <= (index_q == LAST_IDX);
      end
    end
  end

  assign block_out       = block_q;
  assign block_index_out = index_q;
  assign wrap_out        = wrap_q;

`ifdef CONST_SERVER_UNDERFLOW_CHK_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) underflow_err_out <= 1'b0;
    else if ((consumed_in && !ready_out) || (load_valid_in && state_q == READY))
      underflow_err_out <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_constant_block_server.sv
// tb/tb_constant_block_server.sv - self-checking bench for constant_block_server
module tb_constant_block_server;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        load_valid_in = 1'b0;
  logic [31:0] load_block_in = '0;
  logic        restart_in = 1'b0;
  logic        consumed_in = 1'b0;
  logic [31:0] block_out;
  logic [1:0]  block_index_out;
  logic        ready_out;
  logic        wrap_out;
`ifdef CONST_SERVER_UNDERFLOW_CHK_EN
  logic        underflow_err_out;
`endif

  constant_block_server #(
    .REGISTER_SIZE (32),
    .NUM_BLOCKS    (4)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .load_valid_in   (load_valid_in),
    .load_block_in   (load_block_in),
    .restart_in      (restart_in),
    .consumed_in     (consumed_in),
    .block_out       (block_out),
    .block_index_out (block_index_out),
    .ready_out       (ready_out),
    .wrap_out        (wrap_out)
`ifdef CONST_SERVER_UNDERFLOW_CHK_EN
    ,
    .underflow_err_out (underflow_err_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        consume;
    logic        restart;
    logic [31:0] blk;
    logic [1:0]  idx;
    logic        wrap;
  } vec_t;

  typedef struct {
    logic [31:0] blk;
    logic [1:0]  idx;
    logic        wrap;
    logic        ready;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk_outs(input string name, input logic [31:0] blk, input logic [1:0] idx,
                          input logic wrap, input logic rdy);
    chk({name, ".block"}, block_out, blk);
    chk({name, ".index"}, {30'd0, block_index_out}, {30'd0, idx});
    chk({name, ".wrap"},  {31'd0, wrap_out}, {31'd0, wrap});
    chk({name, ".ready"}, {31'd0, ready_out}, {31'd0, rdy});
  endtask

  task automatic load_blocks(input logic [31:0] base, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      load_valid_in = 1'b1;
      load_block_in = base + 32'(i);
      step();
    end
    load_valid_in = 1'b0;
    load_block_in = '0;
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{1'b1, 1'b0, 32'hA1, 2'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'hA2, 2'd2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'hA3, 2'd3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'hA0, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'hA1, 2'd1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'hA2, 2'd2, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'hA3, 2'd3, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'hA0, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'hA1, 2'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'hA1, 2'd1, 1'b0};  // idle: hold
    vecs[10] = '{1'b1, 1'b0, 32'hA2, 2'd2, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'hA0, 2'd0, 1'b0};  // restart beats consume
    vecs[12] = '{1'b1, 1'b0, 32'hA1, 2'd1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'hA2, 2'd2, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'hA3, 2'd3, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 32'hA0, 2'd0, 1'b0};  // restart at last index: no wrap
    vecs[16] = '{1'b0, 1'b1, 32'hA0, 2'd0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 32'hA1, 2'd1, 1'b0};

    // Reset state
    #2;
    chk_outs("reset", 32'h0, 2'd0, 1'b0, 1'b0);
`ifdef CONST_SERVER_UNDERFLOW_CHK_EN
    chk("reset.underflow", {31'd0, underflow_err_out}, 32'd0);
`endif
    step();
    rst_in = 1'b1;
    step();

    // Clean load, priming cycle, then ready with block 0
    load_blocks(32'hA0, 0, 4);
    chk_outs("priming", 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    chk_outs("ready", 32'hA0, 2'd0, 1'b0, 1'b1);
`ifdef CONST_SERVER_UNDERFLOW_CHK_EN
    chk("clean.underflow", {31'd0, underflow_err_out}, 32'd0);
`endif

    // Table-driven consume / restart stream through the scoreboard
    for (int i = 0; i < 18; i++) begin
      consumed_in = vecs[i].consume;
      restart_in  = vecs[i].restart;
      sb.push_back('{vecs[i].blk, vecs[i].idx, vecs[i].wrap, 1'b1});
      step();
      if (sb.size() == 0) begin
        chk($sformatf("vec%0d.sb_empty", i), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk_outs($sformatf("vec%0d", i), e.blk, e.idx, e.wrap, e.ready);
      end
    end
    consumed_in = 1'b0;
    restart_in  = 1'b0;

    // Loads while READY are ignored: constant unchanged
    load_valid_in = 1'b1;
    load_block_in = 32'hDEAD;
    step();
    load_valid_in = 1'b0;
    chk_outs("ready_load", 32'hA1, 2'd1, 1'b0, 1'b1);
    restart_in = 1'b1;
    step();
    restart_in = 1'b0;
    chk_outs("ready_load.rst", 32'hA0, 2'd0, 1'b0, 1'b1);
    consumed_in = 1'b1;
    step();
    consumed_in = 1'b0;
    chk_outs("ready_load.cons", 32'hA1, 2'd1, 1'b0, 1'b1);
`ifdef CONST_SERVER_UNDERFLOW_CHK_EN
    chk("ready_load.underflow", {31'd0, underflow_err_out}, 32'd1);
`endif

    // Activity before READY is ignored
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
`ifdef CONST_SERVER_UNDERFLOW_CHK_EN
    chk("rst2.underflow", {31'd0, underflow_err_out}, 32'd0);
`endif
    load_blocks(32'hA0, 0, 2);
    consumed_in = 1'b1;
    step();
    consumed_in = 1'b0;
    chk_outs("early_cons", 32'h0, 2'd0, 1'b0, 1'b0);
    restart_in = 1'b1;
    step();
    restart_in = 1'b0;
    chk_outs("early_rst", 32'h0, 2'd0, 1'b0, 1'b0);
    load_blocks(32'hA0, 2, 2);
    step();
    chk_outs("late_ready", 32'hA0, 2'd0, 1'b0, 1'b1);
    consumed_in = 1'b1;
    step();
    chk_outs("late_cons1", 32'hA1, 2'd1, 1'b0, 1'b1);
    step();
    consumed_in = 1'b0;
    chk_outs("late_cons2", 32'hA2, 2'd2, 1'b0, 1'b1);
`ifdef CONST_SERVER_UNDERFLOW_CHK_EN
    chk("early.underflow", {31'd0, underflow_err_out}, 32'd1);
`endif

    // Asynchronous reset mid-stream at index 2
    rst_in = 1'b0;
    #1;
    chk_outs("async_rst", 32'h0, 2'd0, 1'b0, 1'b0);
    #3;
    rst_in = 1'b1;
    step();
    load_blocks(32'hB0, 0, 4);
    step();
    chk_outs("reload", 32'hB0, 2'd0, 1'b0, 1'b1);
    consumed_in = 1'b1;
    step();
    consumed_in = 1'b0;
    chk_outs("reload.cons", 32'hB1, 2'd1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/constant_block_server.md
Name: constant_block_server

Overview:
- Supplier side of the constant-block handshake that Montgomery reduction and multiplier consumers use.
- Stores one multi-block constant (k, N or N²), loaded once, block 0 first.
- Presents the current block combinationally-stable on block_out; advances one block in the cycle after each consume pulse.
- Rewinds to block 0 on restart with zero bubble, so every new reduction sees block 0 immediately.

Parameters:
- REGISTER_SIZE, 32, width of one block in bits.
- NUM_BLOCKS, 128, blocks per constant (4096 bits at default); must be ≥ 3.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-low.
- load_valid_in  input  1  write load_block_in at the next load slot.
- load_block_in  input  REGISTER_SIZE  constant block, least significant first.
- restart_in  input  1  rewind to block 0; tie to the consumer's valid_in start.
- consumed_in  input  1  consumer has used block_out; present the next block next cycle.
- block_out  output  REGISTER_SIZE  current constant block.
- block_index_out  output  $clog2(NUM_BLOCKS)  index of block_out.
- ready_out  output  1  constant fully loaded; block_out valid.
- wrap_out  output  1  one-cycle pulse when the index wraps from NUM_BLOCKS-1 to 0.

Behaviour:
- Reset (rst_in=0, async): all outputs and registers are 0, state=LOADING, load_ptr=0. The memory array itself is not cleared.
- States:
  - LOADING: each load_valid_in writes mem[load_ptr] and increments load_ptr. Writes to block 0 and block 1 are also captured into head0/head1 registers. On the write with load_ptr=NUM_BLOCKS-1, next state is PRIMING.
  - PRIMING (1 cycle): block_out←head0, next_reg←head1, index←0, memory read of address 2 issued. Then READY, with ready_out=1.
  - READY: load_valid_in is ignored (the constant is immutable until reset).
- Memory: synchronous read, 1-cycle latency, with read enable. The read address always leads block_out by 2 (mod NUM_BLOCKS). mem_dout holds its value while the read is not enabled.
- consumed_in in READY:
  - block_out←next_reg and next_reg←mem_dout.
  - index←(index+1) mod NUM_BLOCKS; read address←(index+3) mod NUM_BLOCKS.
  - Back-to-back consume every cycle is supported indefinitely with no bubble.
- Wrap: consume at index NUM_BLOCKS-1 gives index 0 and block_out=block 0, and asserts wrap_out for that cycle.
- restart_in in READY:
  - block_out←head0, next_reg←head1, index←0, read address 2 issued.
  - block_out is valid the following cycle.
  - restart and consume together: restart wins and the consume is dropped.
- restart_in or consumed_in while not READY: ignored; outputs stay 0.
- Reset mid-load: the load is discarded and load_ptr returns to 0.

Optional Feature:
- Macro: CONST_SERVER_UNDERFLOW_CHK_EN.
- When defined:
  - Adds output underflow_err_out (1 bit, reset 0).
  - It is sticky-set when consumed_in=1 while ready_out=0, or when load_valid_in=1 while READY.
  - It is cleared only by reset.
- When undefined: the port and logic are absent, and such events are silently ignored as described above.

Decomposition:
- Shared package const_server_pkg:
  - block_t typedef (logic [REGISTER_SIZE-1:0]).
  - State enum {LOADING, PRIMING, READY}.
  - Index-width helper function.
- Natural sub-module: const_block_mem.
  - Simple dual-port RAM: one write port, one enabled synchronous read port, depth NUM_BLOCKS.
  - Inferable as BRAM.

Test Plan:
- Load, then read sequentially (REGISTER_SIZE=32, NUM_BLOCKS=4, blocks 0xA0..0xA3):
  - After the 4th write plus one cycle, ready_out=1, block_out=0xA0, index=0.
- Continuous consume (consumed_in high 9 cycles from READY):
  - block_out sequence is A1,A2,A3,A0,A1,A2,A3,A0,A1 on the following cycles.
  - wrap_out pulses exactly when A0 appears.
- Mid-stream restart (consume twice to A2, then assert restart_in together with consumed_in):
  - The next cycle shows block_out=0xA0, index=0.
  - The following consume gives 0xA1.
- Ignored activity before READY (consumed_in and restart_in pulses during LOADING, after 2 of 4 writes):
  - ready_out stays 0 and block_out stays 0.
  - After the load completes, block_out=0xA0.
  - With CONST_SERVER_UNDERFLOW_CHK_EN, underflow_err_out=1 and stays 1.
- Async reset mid-stream (rst_in low for half a cycle at index 2):
  - All outputs go to 0 immediately.
  - Reloading 0xB0..0xB3 yields block_out=0xB0.
